seq_word_comparator: RTL and testbench

//  Multi-cycle magnitude comparator for two WIDTH-bit unsigned operands.
//  - Processes one 4-bit nibble per cycle, LSB nibble first.
//  - Each nibble's G/L/E result is registered and fed back as the cascade input
//    for the next, more significant nibble.
//  - Sits between operand producers and control logic that needs a >, <, == verdict.
//  - Uses a valid/ready handshake on both the operand side and the result side.

---
 rtl/seq_word_comparator_pkg.sv | 12 +
 rtl/seq_word_comparator_nibble_cmp_stage.sv | 22 ++
 rtl/seq_word_comparator.sv | 118 +++++++++++
 tb/tb_seq_word_comparator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_word_comparator_pkg.sv
// Shared definitions for the nibble-serial magnitude comparator.
package seq_word_comparator_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_word_comparator_nibble_cmp_stage.sv
// One 4-bit slice of the G/L/E cascade; the more significant nibble wins
// unless it is equal, in which case the incoming cascade result passes through.
module nibble_cmp_stage
    import seq_word_comparator_pkg::*;
(
    input  logic [NIBBLE_W-1:0] an,
    input  logic [NIBBLE_W-1:0] bn,
    input  logic                g_in,
    input  logic                l_in,
    input  logic                e_in,
    output logic                g,
    output logic                l,
    output logic                e
);

    always_comb begin
        g = (an > bn) | ((an == bn) & g_in);
        l = (an < bn) | ((an == bn) & l_in);
        e = (an == bn) & e_in;
    end

endmodule

// File: rtl/seq_word_comparator.sv
// Multi-cycle unsigned comparator: one nibble per cycle, LSB first, with
// valid/ready handshakes on the operand and verdict sides.
module seq_word_comparator
    import seq_word_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = $clog2(NIBBLES) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             cas_g;
    logic             cas_l;
    logic             cas_e;
    logic             g_nx;
    logic             l_nx;
    logic             e_nx;

    nibble_cmp_stage u_stage (
        .an   (sa[NIBBLE_W-1:0]),
        .bn   (sb[NIBBLE_W-1:0]),
        .g_in (cas_g),
        .l_in (cas_l),
        .e_in (cas_e),
        .g    (g_nx),
        .l    (l_nx),
        .e    (e_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sa          <= '0;
            sb          <= '0;
            cas_g       <= 1'b0;
            cas_l       <= 1'b0;
            cas_e       <= 1'b1;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            gt          <= 1'b0;
            lt          <= 1'b0;
            eq          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        sa          <= a;
                        sb          <= b;
                        cas_g       <= 1'b0;
                        cas_l       <= 1'b0;
                        cas_e       <= 1'b1;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    cas_g <= g_nx;
                    cas_l <= l_nx;
                    cas_e <= e_nx;
                    sa    <= sa >> NIBBLE_W;
                    sb    <= sb >> NIBBLE_W;
                    cnt   <= cnt + 1'b1;
                    // Verdict outputs take the final stage result directly so
                    // they are valid on the same edge that raises res_valid.
                    if (cnt == CNT_W'(NIBBLES - 1)) begin
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                        gt        <= g_nx;
                        lt        <= l_nx;
                        eq        <= e_nx;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        gt          <= 1'b0;
                        lt          <= 1'b0;
                        eq          <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                    gt          <= 1'b0;
                    lt          <= 1'b0;
                    eq          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_word_comparator.sv
// Bench for seq_word_comparator: directed scenarios plus random pairs checked
// against plain integer comparison, on a 16-bit and a 4-bit instance.
module tb_seq_word_comparator;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic         gt, lt, eq, busy;

    logic         s4_valid, s4_ready, r4_valid, r4_ready;
    logic [3:0]   a4, b4;
    logic         gt4, lt4, eq4, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_word_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b),
        .res_valid(res_valid), .res_ready(res_ready),
        .gt(gt), .lt(lt), .eq(eq), .busy(busy)
    );

    seq_word_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(s4_valid), .start_ready(s4_ready),
        .a(a4), .b(b4),
        .res_valid(r4_valid), .res_ready(r4_ready),
        .gt(gt4), .lt(lt4), .eq(eq4), .busy(busy4)
    );

    function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return 3'b001;
    endfunction

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int i = 0; i < 64 && !start_ready; i++) begin
            @(posedge clk); #1;
        end
        a = av; b = bv; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) lat = -1;
    endtask

    task automatic release_result;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
        s4_valid = 1'b0; r4_ready = 1'b0; a4 = '0; b4 = '0;
        #12;
        checks++;
        if ({start_ready, res_valid, busy, gt, lt, eq} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=100000", {start_ready, res_valid, busy, gt, lt, eq});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({start_ready, res_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got=%b exp=100", {start_ready, res_valid, busy});
        end
    endtask

    task automatic test_equal;
        int lat;
        start_op(16'h1234, 16'h1234);
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL eq_run_flags busy=%b start_ready=%b exp busy=1 start_ready=0", busy, start_ready);
        end
        wait_result(lat);
        checks++;
        if (lat !== NIB) begin
            errors++;
            $display("FAIL eq_latency got=%0d exp=%0d", lat, NIB);
        end
        checks++;
        if ({gt, lt, eq} !== 3'b001) begin
            errors++;
            $display("FAIL eq_verdict got=%b exp=001", {gt, lt, eq});
        end
        release_result();
        checks++;
        if ({res_valid, gt, lt, eq, start_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL eq_release got=%b exp=00001", {res_valid, gt, lt, eq, start_ready});
        end
    endtask

    task automatic test_msb_override;
        int lat;
        start_op(16'h8000, 16'h7FFF);
        wait_result(lat);
        checks++;
        if (lat !== NIB || {gt, lt, eq} !== 3'b100) begin
            errors++;
            $display("FAIL msb_override got lat=%0d gle=%b exp lat=%0d gle=100", lat, {gt, lt, eq}, NIB);
        end
        release_result();
    endtask

    task automatic test_lsb_decides;
        int lat;
        start_op(16'h1230, 16'h1231);
        wait_result(lat);
        checks++;
        if (lat !== NIB || {gt, lt, eq} !== 3'b010) begin
            errors++;
            $display("FAIL lsb_decides got lat=%0d gle=%b exp lat=%0d gle=010", lat, {gt, lt, eq}, NIB);
        end
        release_result();
    endtask

    task automatic test_backpressure;
        int lat;
        start_op(16'h00FF, 16'h0100);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom);
            start_valid = (i % 2 == 0);
            @(posedge clk); #1;
            checks++;
            if ({res_valid, gt, lt, eq, start_ready} !== 5'b10100) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got=%b exp=10100", i, {res_valid, gt, lt, eq, start_ready});
            end
        end
        start_valid = 1'b0;
        release_result();
        checks++;
        if ({res_valid, start_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release got=%b exp=01", {res_valid, start_ready});
        end
        for (int i = 0; i < NIB + 2; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, res_valid, start_ready} !== 3'b001) begin
            errors++;
            $display("FAIL backpressure_no_capture got=%b exp=001", {busy, res_valid, start_ready});
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        start_op(16'hFFFF, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, busy, gt, lt, eq} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_mid_run got=%b exp=100000", {start_ready, res_valid, busy, gt, lt, eq});
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(16'h0001, 16'h0000);
        wait_result(lat);
        checks++;
        if (lat !== NIB || {gt, lt, eq} !== 3'b100) begin
            errors++;
            $display("FAIL after_reset got lat=%0d gle=%b exp lat=%0d gle=100", lat, {gt, lt, eq}, NIB);
        end
        release_result();
    endtask

    task automatic test_random;
        int lat;
        logic [W-1:0] av, bv;
        logic [2:0] exp_v;
        for (int n = 0; n < 1000; n++) begin
            av = W'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? av : W'($urandom);
            if ($urandom_range(0, 7) == 0) bv = av ^ W'(1 << $urandom_range(0, W - 1));
            exp_v = model(av, bv);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            start_op(av, bv);
            wait_result(lat);
            checks++;
            if (lat !== NIB || {gt, lt, eq} !== exp_v || !$onehot({gt, lt, eq})) begin
                errors++;
                $display("FAIL random a=%h b=%h got lat=%0d gle=%b exp lat=%0d gle=%b",
                         av, bv, lat, {gt, lt, eq}, NIB, exp_v);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                checks++;
                if ({res_valid, gt, lt, eq} !== {1'b1, exp_v}) begin
                    errors++;
                    $display("FAIL random_hold a=%h b=%h got=%b exp=1%b", av, bv, {res_valid, gt, lt, eq}, exp_v);
                end
            end
            release_result();
            checks++;
            if ({res_valid, gt, lt, eq} !== 4'b0000) begin
                errors++;
                $display("FAIL random_clear got=%b exp=0000", {res_valid, gt, lt, eq});
            end
        end
    endtask

    task automatic test_width4;
        int lat;
        logic [2:0] exp_v;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                exp_v = (x > y) ? 3'b100 : (x < y) ? 3'b010 : 3'b001;
                for (int i = 0; i < 64 && !s4_ready; i++) begin
                    @(posedge clk); #1;
                end
                a4 = 4'(x); b4 = 4'(y); s4_valid = 1'b1;
                @(posedge clk); #1;
                s4_valid = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
                lat = 0;
                while (!r4_valid && lat < 64) begin
                    @(posedge clk); #1;
                    lat++;
                end
                checks++;
                if (lat !== 1 || {gt4, lt4, eq4} !== exp_v || !$onehot({gt4, lt4, eq4})) begin
                    errors++;
                    $display("FAIL width4 a=%0d b=%0d got lat=%0d gle=%b exp lat=1 gle=%b",
                             x, y, lat, {gt4, lt4, eq4}, exp_v);
                end
                r4_ready = 1'b1;
                @(posedge clk); #1;
                r4_ready = 1'b0;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_equal();
        test_msb_override();
        test_lsb_decides();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
